// File: rtl/fetch_stage.sv
// IF stage: issues instruction-memory requests at the current PC and fills the IF/ID register.
// A one-entry skid buffer absorbs a fetch that completes while ID is stalled on a load-use hazard.
module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int          MAX_WAIT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] pc_4,
   output logic        pc_en,
   input  logic        load_use,
   input  logic        jp_success,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_4,
   output logic        fetch_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   localparam int            WW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

   logic [1:0]    state_q, state_d;
   logic          id_valid_q, id_valid_d;
   logic [31:0]   id_instr_q, id_instr_d;
   logic [31:0]   id_pc_q, id_pc_d;
   logic [31:0]   id_pc_4_q, id_pc_4_d;
   logic          skid_vld_q, skid_vld_d;
   logic [31:0]   skid_instr_q, skid_instr_d;
   logic [31:0]   skid_pc_q, skid_pc_d;
   logic [31:0]   skid_pc_4_q, skid_pc_4_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          err_q, err_d;

   // rst gates the handshake outputs so nothing leaks out while reset is held
   assign imem_req  = (state_q == S_FETCH) && !jp_success && !rst;
   assign imem_addr = pc;
   assign pc_en     = !rst && !jp_success &&
                      (((state_q == S_FETCH) && imem_ack && !load_use) ||
                       ((state_q == S_STALL) && !load_use));

   always_comb begin
      state_d      = state_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc_4_d    = id_pc_4_q;
      skid_vld_d   = skid_vld_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_pc_4_d  = skid_pc_4_q;
      wcnt_d       = '0;

      if (jp_success) begin
         state_d    = S_FETCH;
         id_valid_d = 1'b0;
         id_instr_d = NOP_INSTR;
         skid_vld_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ack && !load_use) begin
                  id_valid_d = 1'b1;
                  id_instr_d = imem_rdata;
                  id_pc_d    = pc;
                  id_pc_4_d  = pc_4;
               end else if (imem_ack) begin
                  skid_vld_d   = 1'b1;
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = pc;
                  skid_pc_4_d  = pc_4;
                  state_d      = S_STALL;
               end else if (!load_use) begin
                  id_valid_d = 1'b0;
                  id_instr_d = NOP_INSTR;
               end
               if (!imem_ack)
                  wcnt_d = (wcnt_q == WMAX) ? WMAX : wcnt_q + WW'(1);
            end
            S_STALL: begin
               if (!load_use) begin
                  id_valid_d = skid_vld_q;
                  id_instr_d = skid_instr_q;
                  id_pc_d    = skid_pc_q;
                  id_pc_4_d  = skid_pc_4_q;
                  skid_vld_d = 1'b0;
                  state_d    = S_FETCH;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      err_d = err_q || (wcnt_d == WMAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         id_valid_q   <= 1'b0;
         id_instr_q   <= NOP_INSTR;
         id_pc_q      <= '0;
         id_pc_4_q    <= '0;
         skid_vld_q   <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_pc_4_q  <= '0;
         wcnt_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pc_4_q    <= id_pc_4_d;
         skid_vld_q   <= skid_vld_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_pc_4_q  <= skid_pc_4_d;
         wcnt_q       <= wcnt_d;
         err_q        <= err_d;
      end
   end

   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_pc_4   = id_pc_4_q;
   assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, load-use skid, flush and timeout.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, load_use, jp_success, imem_ack;
   logic [31:0] pc, pc_4, imem_rdata;
   logic        pc_en, imem_req, id_valid, fetch_err;
   logic [31:0] imem_addr, id_instr, id_pc, id_pc_4;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_stage #(.NOP_INSTR(NOP), .MAX_WAIT(15)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_4(pc_4), .pc_en(pc_en),
      .load_use(load_use), .jp_success(jp_success),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_4(id_pc_4),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // advance one edge and settle past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // leaves the bench in the IDLE cycle right after reset
   task automatic do_reset();
      rst = 1'b1; load_use = 1'b0; jp_success = 1'b0; imem_ack = 1'b0;
      pc = '0; pc_4 = 32'd4; imem_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_use = 1'b0; jp_success = 1'b0; imem_ack = 1'b1;
      pc = 32'h100; pc_4 = 32'h104; imem_rdata = 32'hDEAD_BEEF;
      tick();
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
      n_chk++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en: got %b want 0", pc_en); end
      n_chk++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
      n_chk++; if (id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", id_instr, NOP); end
      n_chk++; if (id_pc !== 32'h0 || id_pc_4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h/%h want 0/0", id_pc, id_pc_4); end
      n_chk++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", fetch_err); end
      rst = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: got req=%b pc_en=%b want 0/0", imem_req, pc_en); end
      n_chk++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL idle_addr: got %h want 00000100", imem_addr); end
      tick();
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_entry_req: got %b want 1", imem_req); end
   endtask

   task automatic test_stream();
      do_reset();
      tick();
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc = 32'(4 * i); pc_4 = 32'(4 * i + 4); imem_rdata = 32'h2001_0001 + 32'(i);
         #1;
         n_chk++; if (pc_en !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_pc_en[%0d]: got pc_en=%b req=%b want 1/1", i, pc_en, imem_req); end
         n_chk++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
         tick();
         n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_pc_4 !== 32'(4 * i + 4))
            begin n_fail++; $display("FAIL stream_id[%0d]: got v=%b pc=%h pc4=%h want 1/%h/%h", i, id_valid, id_pc, id_pc_4, 32'(4 * i), 32'(4 * i + 4)); end
         n_chk++; if (id_instr !== 32'h2001_0001 + 32'(i)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, id_instr, 32'h2001_0001 + 32'(i)); end
      end
   endtask

   // continues from test_stream: ID holds pc 0x8
   task automatic test_wait_states();
      pc = 32'h10; pc_4 = 32'h14; imem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_chk++; if (pc_en !== 1'b0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_pc_en[%0d]: got pc_en=%b req=%b want 0/1", i, pc_en, imem_req); end
         tick();
         n_chk++; if (id_valid !== 1'b0 || id_instr !== NOP) begin n_fail++; $display("FAIL wait_bubble[%0d]: got v=%b instr=%h want 0/%h", i, id_valid, id_instr, NOP); end
         n_chk++; if (id_pc !== 32'h8 || id_pc_4 !== 32'hC) begin n_fail++; $display("FAIL wait_pc_hold[%0d]: got %h/%h want 8/c", i, id_pc, id_pc_4); end
      end
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      #1;
      n_chk++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL wait_ack_pc_en: got %b want 1", pc_en); end
      tick();
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== 32'h1234_5678)
         begin n_fail++; $display("FAIL wait_done: got v=%b pc=%h instr=%h want 1/10/12345678", id_valid, id_pc, id_instr); end
   endtask

   // continues in FETCH with ID = {0x10, 0x12345678}
   task automatic test_load_use();
      pc = 32'h14; pc_4 = 32'h18; imem_ack = 1'b1; imem_rdata = 32'h8C22_0000; load_use = 1'b1;
      #1;
      n_chk++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_ack_pc_en: got %b want 0", pc_en); end
      tick();
      n_chk++; if (id_pc !== 32'h10 || id_instr !== 32'h1234_5678 || id_valid !== 1'b1)
         begin n_fail++; $display("FAIL lu_hold1: got v=%b pc=%h instr=%h want 1/10/12345678", id_valid, id_pc, id_instr); end
      imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
      #1;
      n_chk++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL lu_stall_out: got req=%b pc_en=%b want 0/0", imem_req, pc_en); end
      tick();
      n_chk++; if (id_pc !== 32'h10 || id_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL lu_hold2: got pc=%h instr=%h want 10/12345678", id_pc, id_instr); end
      load_use = 1'b0;
      #1;
      n_chk++; if (pc_en !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL lu_release: got pc_en=%b req=%b want 1/0", pc_en, imem_req); end
      tick();
      n_chk++; if (id_valid !== 1'b1 || id_instr !== 32'h8C22_0000 || id_pc !== 32'h14 || id_pc_4 !== 32'h18)
         begin n_fail++; $display("FAIL lu_skid_out: got v=%b instr=%h pc=%h pc4=%h want 1/8c220000/14/18", id_valid, id_instr, id_pc, id_pc_4); end
      #1;
      n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lu_back_fetch: got req=%b want 1", imem_req); end
   endtask

   task automatic test_flush();
      pc = 32'h20; pc_4 = 32'h24; imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001; load_use = 1'b1;
      tick();
      jp_success = 1'b1;
      #1;
      n_chk++; if (pc_en !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall_out: got pc_en=%b req=%b want 0/0", pc_en, imem_req); end
      tick();
      n_chk++; if (id_valid !== 1'b0 || id_instr !== NOP) begin n_fail++; $display("FAIL flush_id: got v=%b instr=%h want 0/%h", id_valid, id_instr, NOP); end
      jp_success = 1'b0; load_use = 1'b0; pc = 32'h40; pc_4 = 32'h44; imem_rdata = 32'hBBBB_0002;
      #1;
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_en !== 1'b1)
         begin n_fail++; $display("FAIL flush_refetch: got req=%b addr=%h pc_en=%b want 1/40/1", imem_req, imem_addr, pc_en); end
      tick();
      n_chk++; if (id_instr !== 32'hBBBB_0002 || id_pc !== 32'h40 || id_valid !== 1'b1)
         begin n_fail++; $display("FAIL flush_new: got v=%b instr=%h pc=%h want 1/bbbb0002/40", id_valid, id_instr, id_pc); end
      // flush in FETCH with ack pending: ack ignored
      jp_success = 1'b1; imem_rdata = 32'hCCCC_0003; pc = 32'h44; pc_4 = 32'h48;
      #1;
      n_chk++; if (pc_en !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_fetch_out: got pc_en=%b req=%b want 0/0", pc_en, imem_req); end
      tick();
      n_chk++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h40)
         begin n_fail++; $display("FAIL flush_fetch_id: got v=%b instr=%h pc=%h want 0/%h/40", id_valid, id_instr, id_pc, NOP); end
      jp_success = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      imem_ack = 1'b0; pc = 32'h80; pc_4 = 32'h84;
      tick();
      for (int k = 1; k <= 15; k++) begin
         tick();
         n_chk++; if (fetch_err !== (k >= 15)) begin n_fail++; $display("FAIL timeout_err[%0d]: got %b want %b", k, fetch_err, (k >= 15)); end
      end
      imem_ack = 1'b1; imem_rdata = 32'h5555_0005;
      tick();
      n_chk++; if (fetch_err !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h80)
         begin n_fail++; $display("FAIL timeout_sticky: got err=%b v=%b pc=%h want 1/1/80", fetch_err, id_valid, id_pc); end
      rst = 1'b1;
      tick();
      n_chk++; if (fetch_err !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0 || id_pc_4 !== 32'h0)
         begin n_fail++; $display("FAIL timeout_rst: got err=%b v=%b instr=%h pc=%h pc4=%h want 0/0/%h/0/0", fetch_err, id_valid, id_instr, id_pc, id_pc_4, NOP); end
      rst = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL timeout_post_rst: got req=%b pc_en=%b want 0/0", imem_req, pc_en); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_wait_states();
      test_load_use();
      test_flush();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
